alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Shares one combinational 4-bit alu instance (AND/OR/XOR/XNOR, sel-selected) between NREQ requesters.
- Arbitration is round-robin.
- The block registers the winner's operands onto the alu inputs and captures the alu result.
- It returns the result tagged with the requester id.
- When idle for long enough it sequences the alu power domain: isolate, then power off, then wake.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, resp_id width; must equal clog2(NREQ).
- IDLE_TIMEOUT, 16, consecutive idle cycles in IDLE before power-down; 0 disables power-down.
- WAKE_CYCLES, 3, cycles spent in WAKE after power is restored; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester request; held high until granted.
- op_in1  in  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- op_in2  in  4*NREQ  operand B; same packing as op_in1.
- op_sel  in  2*NREQ  opcode; requester i uses bits [2i+1:2i]. 00 AND, 01 OR, 10 XOR, 11 XNOR.
- gnt  out  NREQ  one-hot, combinational; operands sampled at the end of this cycle.
- resp_valid  out  1  single-cycle result strobe.
- resp_id  out  IDW  requester index for the result.
- resp_data  out  4  result value.
- alu_in1  out  4  registered operand A to the alu.
- alu_in2  out  4  registered operand B to the alu.
- alu_sel  out  2  registered opcode to the alu.
- alu_out  in  4  alu result.
- alu_iso  out  1  isolation enable for the alu domain outputs.
- alu_pwr_off  out  1  power switch control for the alu domain; 1 = off.

Behaviour:
- Reset values: all outputs 0; state IDLE; idle_cnt 0; rr pointer NREQ-1, so req[0] has highest priority first.
- Reset is honoured mid-operation: an in-flight op is dropped and no resp_valid is produced.
- States: IDLE, ISSUE, ISO, SLEEP, WAKE.
- IDLE, req nonzero:
  - Winner is the first set req scanning upward from ptr+1, wrapping modulo NREQ.
  - gnt[winner]=1 in this cycle.
  - At the clock edge: alu_in1/alu_in2/alu_sel load the winner's slice; id register loads winner; ptr=winner; idle_cnt=0; next state ISSUE.
- IDLE, req zero: idle_cnt increments, saturating. If IDLE_TIMEOUT!=0 and idle_cnt==IDLE_TIMEOUT-1, next state ISO.
- ISSUE (exactly 1 cycle): gnt=0; resp_data<=alu_out and resp_id<=id at the edge; resp_valid=1 in the following cycle; next state IDLE.
- Latency and throughput:
  - gnt in cycle N gives resp_valid in cycle N+2.
  - One op every 2 cycles.
  - resp_valid for op k coincides with the IDLE cycle that may grant op k+1.
- ISO: alu_iso=1, alu_pwr_off=0.
  - req nonzero: go to WAKE, skipping power-off.
  - Otherwise: go to SLEEP.
- SLEEP: alu_iso=1, alu_pwr_off=1; gnt=0. Any req: alu_pwr_off=0 next cycle, go to WAKE.
- WAKE: alu_iso=1, alu_pwr_off=0 for WAKE_CYCLES cycles, then go to IDLE with alu_iso=0 and idle_cnt=0.
- gnt is 0 in ISO, SLEEP and WAKE. Requests stay pending and are arbitrated on the first IDLE cycle.
- alu_in1/alu_in2/alu_sel hold their last value in all states except at grant.
- alu_out is ignored outside ISSUE.
- alu_iso and alu_pwr_off are registered: glitch-free and decoded from state.
- req bits that drop before grant are simply not served.
- gnt never asserts for a req bit that is 0.

Decomposition:
- Include file alu_sched_defs.vh holds:
  - state encodings (3-bit);
  - opcode constants SEL_AND=2'b00, SEL_OR=2'b01, SEL_XOR=2'b10, SEL_XNOR=2'b11.
- Sub-module rr_arbiter (parameter NREQ) takes req, ptr and en, and produces combinational one-hot gnt plus the encoded winner index.
- alu_sched instantiates rr_arbiter once. The FSM, registers and power sequencing stay in alu_sched.

Test Plan:
- Single op: req=0001, in1=4'hC, in2=4'hA, sel=00 → gnt=0001 in cycle N; resp_valid at N+2 with resp_id=0, resp_data=4'h8. Repeat with sel 01/10/11 → 4'hE, 4'h6, 4'h9.
- Round-robin: req=1111 held, each requester dropping its bit one cycle after its gnt → grants in order 0,1,2,3, two cycles apart; resp_id sequence 0,1,2,3.
- Contention after a grant: last grant id 2; req=0101 → next gnt=0001 (id 0); then gnt=0100 (id 2).
- Power-down and wake: no req for 16 cycles → ISO (iso=1, pwr_off=0) for 1 cycle, then SLEEP (pwr_off=1). req[3] in SLEEP → pwr_off=0 next cycle, 3 WAKE cycles, then IDLE with iso=0 and gnt=1000. Req arriving in ISO → goes straight to WAKE; pwr_off never rises.
- Async reset asserted mid-ISSUE → all outputs 0 immediately; no resp_valid after release; first grant goes to the lowest set req.
- IDLE_TIMEOUT=0 build: 100 idle cycles → alu_iso and alu_pwr_off stay 0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
// alu_sched_pkg : shared constants for the alu scheduler
// Rev 1.0
// ============================================================================
package alu_sched_pkg;

`include "alu_sched_defs.vh"

    localparam int c_STATE_W = 3;

endpackage
`default_nettype wire

// File: rtl/alu_sched_defs.vh
// ============================================================================
// alu_sched_defs.vh : FSM state encodings and alu opcode constants
// Rev 1.0
// ============================================================================
`ifndef ALU_SCHED_DEFS_VH
`define ALU_SCHED_DEFS_VH

localparam logic [2:0] c_ST_IDLE  = 3'd0;
localparam logic [2:0] c_ST_ISSUE = 3'd1;
localparam logic [2:0] c_ST_ISO   = 3'd2;
localparam logic [2:0] c_ST_SLEEP = 3'd3;
localparam logic [2:0] c_ST_WAKE  = 3'd4;

localparam logic [1:0] SEL_AND  = 2'b00;
localparam logic [1:0] SEL_OR   = 2'b01;
localparam logic [1:0] SEL_XOR  = 2'b10;
localparam logic [1:0] SEL_XNOR = 2'b11;

`endif

// File: rtl/alu_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin arbiter, search starts at ptr+1
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  winner,
    output logic            any_req
);

    logic [31:0] w_idx;

    always_comb begin
        gnt     = '0;
        winner  = '0;
        any_req = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = (32'(ptr) + 32'(i)) % 32'(NREQ);
            if (en && !any_req && req[w_idx[IDW-1:0]]) begin
                any_req                = 1'b1;
                gnt[w_idx[IDW-1:0]]    = 1'b1;
                winner                 = w_idx[IDW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// alu_sched : round-robin sharing of one 4-bit alu with idle power sequencing
// Rev 1.0
// ============================================================================
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int IDW          = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int WAKE_CYCLES  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] op_in1,
    input  logic [4*NREQ-1:0] op_in2,
    input  logic [2*NREQ-1:0] op_sel,
    output logic [NREQ-1:0]   gnt,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [3:0]        resp_data,
    output logic [3:0]        alu_in1,
    output logic [3:0]        alu_in2,
    output logic [1:0]        alu_sel,
    input  logic [3:0]        alu_out,
    output logic              alu_iso,
    output logic              alu_pwr_off
);

    localparam int c_CNT_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int c_WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]  c_IDLE_LAST = c_CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [c_WAKE_W-1:0] c_WAKE_LAST = c_WAKE_W'(WAKE_CYCLES - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_CNT_W-1:0]   r_idle_cnt;
    logic [c_WAKE_W-1:0]  r_wake_cnt;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_id;
    logic [3:0]           r_alu_in1;
    logic [3:0]           r_alu_in2;
    logic [1:0]           r_alu_sel;
    logic                 r_resp_valid;
    logic [IDW-1:0]       r_resp_id;
    logic [3:0]           r_resp_data;
    logic                 r_alu_iso;
    logic                 r_alu_pwr_off;

    logic                 w_arb_en;
    logic [NREQ-1:0]      w_gnt;
    logic [IDW-1:0]       w_winner;
    logic                 w_any;

    // Gating with rst keeps gnt low while reset is held, even with req pending.
    assign w_arb_en = (r_state == c_ST_IDLE) && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .winner  (w_winner),
        .any_req (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_idle_cnt    <= '0;
            r_wake_cnt    <= '0;
            r_ptr         <= IDW'(NREQ - 1);
            r_id          <= '0;
            r_alu_in1     <= '0;
            r_alu_in2     <= '0;
            r_alu_sel     <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_data   <= '0;
            r_alu_iso     <= 1'b0;
            r_alu_pwr_off <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_alu_in1  <= op_in1[{w_winner, 2'b00} +: 4];
                        r_alu_in2  <= op_in2[{w_winner, 2'b00} +: 4];
                        r_alu_sel  <= op_sel[{w_winner, 1'b0} +: 2];
                        r_id       <= w_winner;
                        r_ptr      <= w_winner;
                        r_idle_cnt <= '0;
                        r_state    <= c_ST_ISSUE;
                    end else begin
                        if (r_idle_cnt != '1) begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                        if ((IDLE_TIMEOUT != 0) && (r_idle_cnt == c_IDLE_LAST)) begin
                            r_state   <= c_ST_ISO;
                            r_alu_iso <= 1'b1;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_resp_data  <= alu_out;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= c_ST_IDLE;
                end
                c_ST_ISO: begin
                    // A request arriving while isolating skips the power-off step.
                    r_wake_cnt <= '0;
                    if (|req) begin
                        r_state <= c_ST_WAKE;
                    end else begin
                        r_state       <= c_ST_SLEEP;
                        r_alu_pwr_off <= 1'b1;
                    end
                end
                c_ST_SLEEP: begin
                    if (|req) begin
                        r_alu_pwr_off <= 1'b0;
                        r_wake_cnt    <= '0;
                        r_state       <= c_ST_WAKE;
                    end
                end
                c_ST_WAKE: begin
                    if (r_wake_cnt == c_WAKE_LAST) begin
                        r_state    <= c_ST_IDLE;
                        r_alu_iso  <= 1'b0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state       <= c_ST_IDLE;
                    r_alu_iso     <= 1'b0;
                    r_alu_pwr_off <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = w_gnt;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_data   = r_resp_data;
    assign alu_in1     = r_alu_in1;
    assign alu_in2     = r_alu_in2;
    assign alu_sel     = r_alu_sel;
    assign alu_iso     = r_alu_iso;
    assign alu_pwr_off = r_alu_pwr_off;

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// tb_alu_sched : directed self-checking bench for alu_sched
// Rev 1.0
// ============================================================================
module tb_alu_sched;
    import alu_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req;
    logic [15:0] op_in1, op_in2;
    logic [7:0]  op_sel;
    logic [3:0]  gnt, resp_data, alu_in1, alu_in2, alu_out;
    logic [1:0]  resp_id, alu_sel;
    logic        resp_valid, alu_iso, alu_pwr_off;

    logic [3:0]  req0 = '0;
    logic [15:0] op0 = '0;
    logic [7:0]  sel0 = '0;
    logic [3:0]  gnt0, resp_data0, alu_in1_0, alu_in2_0, alu_out0;
    logic [1:0]  resp_id0, alu_sel0;
    logic        resp_valid0, alu_iso0, alu_pwr_off0;

    int n_chk = 0;
    int n_err = 0;
    logic nto_seen = 1'b0;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
        case (s)
            SEL_AND: return a & b;
            SEL_OR:  return a | b;
            SEL_XOR: return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    assign alu_out  = alu_f(alu_in1, alu_in2, alu_sel);
    assign alu_out0 = alu_f(alu_in1_0, alu_in2_0, alu_sel0);

    alu_sched #(.NREQ(4), .IDW(2), .IDLE_TIMEOUT(16), .WAKE_CYCLES(3)) u_dut (
        .clk(clk), .rst(rst), .req(req), .op_in1(op_in1), .op_in2(op_in2),
        .op_sel(op_sel), .gnt(gnt), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_sel(alu_sel), .alu_out(alu_out), .alu_iso(alu_iso),
        .alu_pwr_off(alu_pwr_off)
    );

    alu_sched #(.NREQ(4), .IDW(2), .IDLE_TIMEOUT(0), .WAKE_CYCLES(3)) u_dut_nto (
        .clk(clk), .rst(rst), .req(req0), .op_in1(op0), .op_in2(op0),
        .op_sel(sel0), .gnt(gnt0), .resp_valid(resp_valid0), .resp_id(resp_id0),
        .resp_data(resp_data0), .alu_in1(alu_in1_0), .alu_in2(alu_in2_0),
        .alu_sel(alu_sel0), .alu_out(alu_out0), .alu_iso(alu_iso0),
        .alu_pwr_off(alu_pwr_off0)
    );

    always @(negedge clk) begin
        if (!rst && (alu_iso0 || alu_pwr_off0 || resp_valid0 || (|gnt0)
                     || (|resp_data0) || (|resp_id0))) begin
            nto_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int id, input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] s);
        op_in1[4*id +: 4] = a;
        op_in2[4*id +: 4] = b;
        op_sel[2*id +: 2] = s;
    endtask

    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] s, input logic [3:0] e);
        set_slot(id, a, b, s);
        req = 4'(1 << id);
        #1;
        chk("op_gnt", gnt, 32'(1 << id));
        cyc();
        req = '0;
        chk("op_issue_gnt", gnt, 0);
        chk("op_issue_rv", resp_valid, 0);
        cyc();
        chk("op_rv", resp_valid, 1);
        chk("op_id", resp_id, 32'(id));
        chk("op_data", resp_data, e);
        cyc();
        chk("op_rv_drop", resp_valid, 0);
    endtask

    logic [3:0] sel_exp [4] = '{4'h8, 4'hE, 4'h6, 4'h9};
    logic [3:0] rr_exp  [4] = '{4'h3, 4'h7, 4'h5, 4'h0};

    initial begin
        req = '0; op_in1 = '0; op_in2 = '0; op_sel = '0;
        rst = 1'b1;
        repeat (2) cyc();
        chk("reset_outs", {gnt, resp_valid, resp_id, resp_data, alu_in1, alu_in2,
                           alu_sel, alu_iso, alu_pwr_off}, 0);
        rst = 1'b0;
        cyc();

        for (int s = 0; s < 4; s++) do_op(0, 4'hC, 4'hA, 2'(s), sel_exp[s]);

        // Round robin from a fresh pointer
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        set_slot(0, 4'hF, 4'h3, SEL_AND);
        set_slot(1, 4'h5, 4'h6, SEL_OR);
        set_slot(2, 4'h9, 4'hC, SEL_XOR);
        set_slot(3, 4'hA, 4'h5, SEL_XNOR);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_gnt", gnt, 32'(1 << i));
            if (i > 0) begin
                chk("rr_rv", resp_valid, 1);
                chk("rr_id", resp_id, 32'(i - 1));
                chk("rr_data", resp_data, rr_exp[i-1]);
            end
            cyc();
            req[i] = 1'b0;
            chk("rr_issue_gnt", gnt, 0);
            cyc();
        end
        chk("rr_rv_last", resp_valid, 1);
        chk("rr_id_last", resp_id, 3);
        chk("rr_data_last", resp_data, 4'h0);
        cyc();

        // Contention after grant to id 2
        do_op(2, 4'h6, 4'h3, SEL_AND, 4'h2);
        set_slot(2, 4'h9, 4'hC, SEL_XOR);
        req = 4'b0101;
        #1;
        chk("cont_gnt0", gnt, 4'b0001);
        cyc(); req = 4'b0100; cyc();
        #1;
        chk("cont_gnt2", gnt, 4'b0100);
        chk("cont_id0", resp_id, 0);
        chk("cont_data0", resp_data, 4'h3);
        cyc(); req = '0; cyc();
        chk("cont_rv2", resp_valid, 1);
        chk("cont_id2", resp_id, 2);
        chk("cont_data2", resp_data, 4'h5);

        // Idle timeout into SLEEP, wake on req[3]
        repeat (15) cyc();
        chk("pd_pre_iso", alu_iso, 0);
        cyc();
        chk("pd_iso", {alu_iso, alu_pwr_off}, 2'b10);
        cyc();
        chk("pd_sleep", {alu_iso, alu_pwr_off}, 2'b11);
        set_slot(3, 4'h3, 4'h5, SEL_OR);
        req = 4'b1000;
        #1;
        chk("pd_sleep_gnt", gnt, 0);
        cyc();
        chk("pd_wake1", {alu_iso, alu_pwr_off}, 2'b10);
        chk("pd_wake1_gnt", gnt, 0);
        cyc(); cyc();
        chk("pd_wake3", {alu_iso, alu_pwr_off}, 2'b10);
        chk("pd_wake3_gnt", gnt, 0);
        cyc();
        #1;
        chk("pd_idle_iso", {alu_iso, alu_pwr_off}, 2'b00);
        chk("pd_idle_gnt", gnt, 4'b1000);
        cyc(); req = '0; cyc();
        chk("pd_id", resp_id, 3);
        chk("pd_data", resp_data, 4'h7);

        // Request arriving in ISO skips power-off
        repeat (16) cyc();
        chk("iso_only", {alu_iso, alu_pwr_off}, 2'b10);
        set_slot(1, 4'h8, 4'h1, SEL_XOR);
        req = 4'b0010;
        for (int w = 0; w < 3; w++) begin
            cyc();
            chk("iso_wake", {alu_iso, alu_pwr_off}, 2'b10);
        end
        cyc();
        #1;
        chk("iso_idle", {alu_iso, alu_pwr_off}, 2'b00);
        chk("iso_idle_gnt", gnt, 4'b0010);
        cyc(); req = '0; cyc();
        chk("iso_id", resp_id, 1);
        chk("iso_data", resp_data, 4'h9);

        // Async reset in the middle of ISSUE
        cyc();
        req = 4'b0110;
        #1;
        chk("ar_gnt", gnt, 4'b0100);
        cyc();
        rst = 1'b1;
        #1;
        chk("ar_outs", {gnt, resp_valid, resp_id, resp_data, alu_in1, alu_in2,
                        alu_sel, alu_iso, alu_pwr_off}, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("ar_first_gnt", gnt, 4'b0010);
        chk("ar_rv0", resp_valid, 0);
        cyc(); req = 4'b0100;
        chk("ar_rv1", resp_valid, 0);
        cyc();
        #1;
        chk("ar_rv_new", resp_valid, 1);
        chk("ar_id_new", resp_id, 1);
        chk("ar_gnt2", gnt, 4'b0100);
        cyc(); req = '0; cyc();
        chk("ar_id2", resp_id, 2);
        chk("ar_data2", resp_data, 4'h5);

        // IDLE_TIMEOUT=0 build never isolates
        repeat (100) cyc();
        chk("nto_quiet", nto_seen, 0);
        chk("nto_pwr", {alu_iso0, alu_pwr_off0}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
